// File: rtl/alu_issue_stage.sv
// Execute-issue stage ahead of a registered ALU: decodes the ALU control code,
// selects/forwards operands, stalls distance-1 dependencies and forwards at distance 2.
module alu_issue_stage #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      in_opcode,
   input  logic [2:0]      in_funct3,
   input  logic            in_funct7b5,
   input  logic [REGW-1:0] in_rs1,
   input  logic [REGW-1:0] in_rs2,
   input  logic [REGW-1:0] in_rd,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] alu_result,
   output logic [2:0]      ALU,
   output logic [XLEN-1:0] Operand1,
   output logic [XLEN-1:0] Operand2,
   output logic            out_valid,
   output logic [REGW-1:0] out_rd,
   output logic            res_valid,
   output logic [REGW-1:0] res_rd,
   output logic            illegal
);

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   // Shift amounts only use the low five bits of the second operand.
   function automatic logic [XLEN-1:0] shamt_mask(input logic [XLEN-1:0] v);
      return {{(XLEN-5){1'b0}}, v[4:0]};
   endfunction

   logic            legal;
   logic            is_r;
   logic [2:0]      code;
   logic [REGW-1:0] rd_eff;
   logic            hazard;
   logic            issue;
   logic            drop_illegal;
   logic            fwd1;
   logic            fwd2;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [XLEN-1:0] op2_sel;

   logic [2:0]      alu_p1;
   logic [XLEN-1:0] op1_p1;
   logic [XLEN-1:0] op2_p1;
   logic            vld_p1;
   logic [REGW-1:0] rd_p1;
   logic            ill_p1;
   logic            vld_p2;
   logic [REGW-1:0] rd_p2;

   always_comb begin
      legal  = 1'b0;
      code   = 3'd0;
      is_r   = (in_opcode == OP_R);
      rd_eff = in_rd;
      case (in_opcode)
         OP_R, OP_I: begin
            case (in_funct3)
               3'b000: begin
                  code  = 3'd0;
                  legal = !(is_r && in_funct7b5);
               end
               3'b101: begin
                  code  = 3'd1;
                  legal = !in_funct7b5;
               end
               3'b110: begin
                  code  = 3'd2;
                  legal = 1'b1;
               end
               3'b111: begin
                  code  = 3'd3;
                  legal = 1'b1;
               end
               default: legal = 1'b0;
            endcase
         end
         OP_LD: legal = 1'b1;
         OP_ST: begin
            legal  = 1'b1;
            rd_eff = '0;
         end
         default: legal = 1'b0;
      endcase
   end

   // Producer one slot ahead has no result yet; x0 never creates a dependency.
   assign hazard = in_valid && legal && vld_p1 && (rd_p1 != '0) &&
                   ((in_rs1 == rd_p1) || (is_r && (in_rs2 == rd_p1)));

   assign in_ready     = reset || flush || !hazard;
   assign issue        = in_valid && legal && !flush && !hazard;
   assign drop_illegal = in_valid && !legal && !flush;

   assign fwd1 = vld_p2 && (rd_p2 != '0) && (in_rs1 == rd_p2);
   assign fwd2 = vld_p2 && (rd_p2 != '0) && (in_rs2 == rd_p2);
   assign src1 = fwd1 ? alu_result : in_rs1_data;
   assign src2 = fwd2 ? alu_result : in_rs2_data;

   always_comb begin
      op2_sel = is_r ? src2 : in_imm;
      if (code == 3'd1) op2_sel = shamt_mask(op2_sel);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         alu_p1 <= '0;
         op1_p1 <= '0;
         op2_p1 <= '0;
         vld_p1 <= 1'b0;
         rd_p1  <= '0;
         ill_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         rd_p2  <= '0;
      end else begin
         // stage 1: ALU input register
         vld_p1 <= issue;
         rd_p1  <= issue ? rd_eff : '0;
         ill_p1 <= drop_illegal;
         if (issue) begin
            alu_p1 <= code;
            op1_p1 <= src1;
            op2_p1 <= op2_sel;
         end
         // stage 2: tracks the ALU's own result register
         vld_p2 <= vld_p1;
         rd_p2  <= rd_p1;
      end
   end

   assign ALU       = alu_p1;
   assign Operand1  = op1_p1;
   assign Operand2  = op2_p1;
   assign out_valid = vld_p1;
   assign out_rd    = rd_p1;
   assign res_valid = vld_p2;
   assign res_rd    = rd_p2;
   assign illegal   = ill_p1;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural registered ALU behind it.
module tb_alu_issue_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic        in_funct7b5;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [31:0] in_rs1_data, in_rs2_data, in_imm;
   logic [31:0] alu_result = 32'h0;
   logic [2:0]  ALU;
   logic [31:0] Operand1, Operand2;
   logic        out_valid;
   logic [4:0]  out_rd;
   logic        res_valid;
   logic [4:0]  res_rd;
   logic        illegal;

   int pass_cnt = 0;
   int total_cnt = 0;

   alu_issue_stage #(.XLEN(32), .REGW(5)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
      .alu_result(alu_result),
      .ALU(ALU), .Operand1(Operand1), .Operand2(Operand2),
      .out_valid(out_valid), .out_rd(out_rd),
      .res_valid(res_valid), .res_rd(res_rd), .illegal(illegal)
   );

   always #5 clock = ~clock;

   // Reference ALU: add, srl, or, and; result registered.
   always @(posedge clock) begin
      case (ALU)
         3'd0: alu_result <= Operand1 + Operand2;
         3'd1: alu_result <= Operand1 >> Operand2[4:0];
         3'd2: alu_result <= Operand1 | Operand2;
         3'd3: alu_result <= Operand1 & Operand2;
         default: alu_result <= 32'h0;
      endcase
   end

   localparam logic [6:0] R  = 7'b0110011;
   localparam logic [6:0] I  = 7'b0010011;
   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic f7, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm);
      in_valid    = v;
      in_opcode   = op;
      in_funct3   = f3;
      in_funct7b5 = f7;
      in_rs1      = rs1;
      in_rs2      = rs2;
      in_rd       = rd;
      in_rs1_data = d1;
      in_rs2_data = d2;
      in_imm      = imm;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      drive(1'b1, I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'd5);
      check("ready_in_reset", 32'(in_ready), 32'd1);
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_alu", 32'(ALU), 32'd0);
      check("rst_op1", Operand1, 32'd0);
      check("rst_op2", Operand2, 32'd0);
      check("rst_out_rd", 32'(out_rd), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_rd", 32'(res_rd), 32'd0);
      check("rst_illegal", 32'(illegal), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);

      // addi x1,x0,5 then ori x2,x0,3
      reset = 1'b0;
      drive(1'b1, I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'd5);
      step();
      check("addi_alu", 32'(ALU), 32'd0);
      check("addi_op1", Operand1, 32'd0);
      check("addi_op2", Operand2, 32'd5);
      check("addi_vld", 32'(out_valid), 32'd1);
      check("addi_rd", 32'(out_rd), 32'd1);
      drive(1'b1, I, 3'b110, 1'b0, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 32'd3);
      check("ori_ready", 32'(in_ready), 32'd1);
      step();
      check("ori_alu", 32'(ALU), 32'd2);
      check("ori_op2", Operand2, 32'd3);
      check("ori_rd", 32'(out_rd), 32'd2);
      check("res_addi", alu_result, 32'd5);
      check("res_rd_addi", 32'(res_rd), 32'd1);
      idle();
      step();
      check("res_ori", alu_result, 32'd3);
      check("idle_vld", 32'(out_valid), 32'd0);
      check("res_vld_ori", 32'(res_valid), 32'd1);
      check("res_rd_ori", 32'(res_rd), 32'd2);
      step();

      // addi x1,x0,7 ; and x3,x1,x1 -> one stall, then forward
      drive(1'b1, I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'd7);
      step();
      drive(1'b1, R, 3'b111, 1'b0, 5'd1, 5'd1, 5'd3, 32'hdead, 32'hbeef, 32'h0);
      check("dep_stall", 32'(in_ready), 32'd0);
      step();
      check("dep_bubble", 32'(out_valid), 32'd0);
      check("dep_res", alu_result, 32'd7);
      check("dep_ready_after", 32'(in_ready), 32'd1);
      step();
      check("fwd_alu", 32'(ALU), 32'd3);
      check("fwd_op1", Operand1, 32'd7);
      check("fwd_op2", Operand2, 32'd7);
      check("fwd_vld", 32'(out_valid), 32'd1);
      check("fwd_rd", 32'(out_rd), 32'd3);
      idle();
      step();
      check("and_res", alu_result, 32'd7);

      // srli x4,x5,0x23 with x5=0x80000000
      drive(1'b1, I, 3'b101, 1'b0, 5'd5, 5'd3, 5'd4, 32'h80000000, 32'h0, 32'h23);
      step();
      check("srli_alu", 32'(ALU), 32'd1);
      check("srli_op1", Operand1, 32'h80000000);
      check("srli_op2", Operand2, 32'd3);
      idle();
      step();
      check("srli_res", alu_result, 32'h10000000);

      // sub, sra, slt are dropped as illegal
      drive(1'b1, R, 3'b000, 1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0);
      check("sub_ready", 32'(in_ready), 32'd1);
      step();
      check("sub_illegal", 32'(illegal), 32'd1);
      check("sub_vld", 32'(out_valid), 32'd0);
      drive(1'b1, R, 3'b101, 1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0);
      check("sra_ready", 32'(in_ready), 32'd1);
      step();
      check("sra_illegal", 32'(illegal), 32'd1);
      check("sra_vld", 32'(out_valid), 32'd0);
      drive(1'b1, R, 3'b010, 1'b0, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0);
      check("slt_ready", 32'(in_ready), 32'd1);
      step();
      check("slt_illegal", 32'(illegal), 32'd1);
      check("slt_vld", 32'(out_valid), 32'd0);
      idle();
      step();
      check("illegal_clear", 32'(illegal), 32'd0);

      // flush on producer issue: consumer not stalled
      drive(1'b1, I, 3'b110, 1'b0, 5'd0, 5'd0, 5'd2, 32'h0, 32'h0, 32'd3);
      step();
      flush = 1'b1;
      drive(1'b1, I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'd7);
      check("flush_ready", 32'(in_ready), 32'd1);
      step();
      check("flush_vld", 32'(out_valid), 32'd0);
      check("flush_res_vld", 32'(res_valid), 32'd1);
      check("flush_res_rd", 32'(res_rd), 32'd2);
      check("flush_no_ill", 32'(illegal), 32'd0);
      flush = 1'b0;
      drive(1'b1, R, 3'b111, 1'b0, 5'd1, 5'd1, 5'd3, 32'h11, 32'h11, 32'h0);
      check("post_flush_ready", 32'(in_ready), 32'd1);
      step();
      check("post_flush_vld", 32'(out_valid), 32'd1);
      check("post_flush_op1", Operand1, 32'h11);
      check("post_flush_rd", 32'(out_rd), 32'd3);
      flush = 1'b1;
      drive(1'b1, R, 3'b000, 1'b1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h0);
      step();
      check("flush_illegal", 32'(illegal), 32'd0);
      flush = 1'b0;
      idle();
      step();
      step();

      // reset while a stall is pending
      drive(1'b1, I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1, 32'h0, 32'h0, 32'd7);
      step();
      drive(1'b1, R, 3'b111, 1'b0, 5'd1, 5'd1, 5'd3, 32'h0, 32'h0, 32'h0);
      check("pre_rst_stall", 32'(in_ready), 32'd0);
      reset = 1'b1;
      step();
      check("rst2_vld", 32'(out_valid), 32'd0);
      check("rst2_alu", 32'(ALU), 32'd0);
      check("rst2_op1", Operand1, 32'd0);
      check("rst2_op2", Operand2, 32'd0);
      check("rst2_rd", 32'(out_rd), 32'd0);
      check("rst2_res_vld", 32'(res_valid), 32'd0);
      check("rst2_res_rd", 32'(res_rd), 32'd0);
      check("rst2_illegal", 32'(illegal), 32'd0);
      check("rst2_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;
      idle();
      step();

      // sw x9,8(x2) then lw x8,4(x2)
      drive(1'b1, ST, 3'b010, 1'b0, 5'd2, 5'd9, 5'd5, 32'h100, 32'h55, 32'd8);
      step();
      check("sw_alu", 32'(ALU), 32'd0);
      check("sw_op1", Operand1, 32'h100);
      check("sw_op2", Operand2, 32'd8);
      check("sw_rd", 32'(out_rd), 32'd0);
      check("sw_vld", 32'(out_valid), 32'd1);
      drive(1'b1, LD, 3'b010, 1'b0, 5'd2, 5'd0, 5'd8, 32'h100, 32'h0, 32'd4);
      check("lw_ready", 32'(in_ready), 32'd1);
      step();
      check("lw_op2", Operand2, 32'd4);
      check("lw_rd", 32'(out_rd), 32'd8);
      idle();
      step();

      // x0 destination: no stall, no forwarding
      drive(1'b1, I, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'd9);
      step();
      check("x0_rd", 32'(out_rd), 32'd0);
      drive(1'b1, R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd6, 32'h0, 32'h0, 32'h0);
      check("x0_ready", 32'(in_ready), 32'd1);
      step();
      check("x0_d1_op1", Operand1, 32'd0);
      check("x0_d1_op2", Operand2, 32'd0);
      check("x0_d1_vld", 32'(out_valid), 32'd1);
      drive(1'b1, R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0);
      check("x0_res_present", alu_result, 32'd9);
      step();
      check("x0_d2_op1", Operand1, 32'd0);
      check("x0_d2_op2", Operand2, 32'd0);
      idle();
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
